// File: rtl/aes_package.sv
// Shared types and constants for the AES request scheduler slice.
package aes_package;

    localparam int unsigned DATA_WIDTH = 128;

    typedef enum logic {
        MODE_ENC = 1'b0,
        MODE_DEC = 1'b1
    } aes_mode_e;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } sched_state_e;

endpackage

// File: rtl/aes_rr_arbiter.sv
// Round-robin arbiter: grants the lowest-index request at or after ptr, wrapping to 0.
module aes_rr_arbiter
    import aes_package::*;
#(
    parameter int unsigned NUM_CH = 4,
    localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant
);

    logic        found;
    int unsigned idx;

    // Scan upward from ptr with wrap; the first asserted request wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned off = 0; off < NUM_CH; off++) begin
            idx = (32'(ptr) + off) % NUM_CH;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_req_scheduler.sv
// Multi-channel request scheduler in front of a shared AES encrypt/decrypt core.
// One request in flight: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Optional watchdog on the WAIT state: define AES_SCHED_TIMEOUT_EN.
module aes_req_scheduler
    import aes_package::*;
#(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned DATA_WIDTH     = aes_package::DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    localparam int unsigned CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            req_valid,
    output logic [NUM_CH-1:0]            req_ready,
    input  logic [NUM_CH-1:0]            req_mode,
    input  logic [NUM_CH*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_CH*DATA_WIDTH-1:0] req_key,
    output logic                         start_encryption,
    output logic                         start_decryption,
    output logic [DATA_WIDTH-1:0]        plaintext_encryption,
    output logic [DATA_WIDTH-1:0]        cyphertext_decryption,
    output logic [DATA_WIDTH-1:0]        key_encryption,
    input  logic [DATA_WIDTH-1:0]        cyphertext_encryption,
    input  logic [DATA_WIDTH-1:0]        plaintext_decryption,
    input  logic                         done_encryption,
    input  logic                         done_decyption,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [CH_W-1:0]              rsp_ch,
    output logic                         rsp_mode,
    output logic [DATA_WIDTH-1:0]        rsp_data,
    output logic                         rsp_err
);

    sched_state_e          state;
    aes_mode_e             mode_q;
    logic [CH_W-1:0]       rr_ptr;
    logic [NUM_CH-1:0]     grant;
    logic [CH_W-1:0]       grant_idx;
    logic [DATA_WIDTH-1:0] grant_data;
    logic [DATA_WIDTH-1:0] grant_key;
    logic                  grant_mode;
    logic                  handshake;
    logic                  done_match;

    aes_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Encode the one-hot grant and select the granted channel's operands.
    always_comb begin
        grant_idx  = '0;
        grant_data = '0;
        grant_key  = '0;
        grant_mode = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                grant_idx  = CH_W'(i);
                grant_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                grant_key  = req_key[i*DATA_WIDTH +: DATA_WIDTH];
                grant_mode = req_mode[i];
            end
        end
    end

    // Reset gates ready so nothing is offered while the FSM is being cleared.
    assign req_ready  = (rst && state == StIdle) ? grant : '0;
    assign handshake  = |req_ready;
    assign done_match = (mode_q == MODE_ENC) ? done_encryption : done_decyption;
    assign rsp_mode   = mode_q;

`ifdef AES_SCHED_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;
    logic             timeout;
    // Counter holds the number of WAIT cycles already spent; the last one is TIMEOUT_CYCLES-1.
    assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rsp_err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign rsp_err        = 1'b0;
`endif

    // Scheduler FSM with registered core strobes, operands and response fields.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state                 <= StIdle;
            mode_q                <= MODE_ENC;
            rr_ptr                <= '0;
            start_encryption      <= 1'b0;
            start_decryption      <= 1'b0;
            plaintext_encryption  <= '0;
            cyphertext_decryption <= '0;
            key_encryption        <= '0;
            rsp_valid             <= 1'b0;
            rsp_ch                <= '0;
            rsp_data              <= '0;
`ifdef AES_SCHED_TIMEOUT_EN
            wait_cnt              <= '0;
            err_q                 <= 1'b0;
`endif
        end else begin
            start_encryption <= 1'b0;
            start_decryption <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (handshake) begin
                        rsp_ch         <= grant_idx;
                        mode_q         <= aes_mode_e'(grant_mode);
                        key_encryption <= grant_key;
                        // Only the operand of the selected direction changes; the other holds.
                        if (grant_mode == MODE_DEC) begin
                            cyphertext_decryption <= grant_data;
                            start_decryption      <= 1'b1;
                        end else begin
                            plaintext_encryption <= grant_data;
                            start_encryption     <= 1'b1;
                        end
                        rr_ptr <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
                        state  <= StIssue;
                    end
                end
                StIssue: begin
`ifdef AES_SCHED_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= StWait;
                end
                StWait: begin
                    if (done_match) begin
                        rsp_data  <= (mode_q == MODE_ENC) ? cyphertext_encryption
                                                          : plaintext_decryption;
                        rsp_valid <= 1'b1;
                        state     <= StResp;
`ifdef AES_SCHED_TIMEOUT_EN
                        err_q     <= 1'b0;
                    end else if (timeout) begin
                        rsp_data  <= '0;
                        rsp_valid <= 1'b1;
                        err_q     <= 1'b1;
                        state     <= StResp;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
`endif
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_req_scheduler.sv
// Directed self-checking bench for aes_req_scheduler (NUM_CH=4, TIMEOUT_CYCLES=8).
module tb_aes_req_scheduler;

    localparam int NCH = 4;
    localparam int DW  = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    req_valid;
    logic [NCH-1:0]    req_ready;
    logic [NCH-1:0]    req_mode;
    logic [NCH*DW-1:0] req_data;
    logic [NCH*DW-1:0] req_key;
    logic              start_encryption;
    logic              start_decryption;
    logic [DW-1:0]     plaintext_encryption;
    logic [DW-1:0]     cyphertext_decryption;
    logic [DW-1:0]     key_encryption;
    logic [DW-1:0]     cyphertext_encryption;
    logic [DW-1:0]     plaintext_decryption;
    logic              done_encryption;
    logic              done_decyption;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_ch;
    logic              rsp_mode;
    logic [DW-1:0]     rsp_data;
    logic              rsp_err;

    aes_req_scheduler #(
        .NUM_CH         (NCH),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .req_mode              (req_mode),
        .req_data              (req_data),
        .req_key               (req_key),
        .start_encryption      (start_encryption),
        .start_decryption      (start_decryption),
        .plaintext_encryption  (plaintext_encryption),
        .cyphertext_decryption (cyphertext_decryption),
        .key_encryption        (key_encryption),
        .cyphertext_encryption (cyphertext_encryption),
        .plaintext_decryption  (plaintext_decryption),
        .done_encryption       (done_encryption),
        .done_decyption        (done_decyption),
        .rsp_valid             (rsp_valid),
        .rsp_ready             (rsp_ready),
        .rsp_ch                (rsp_ch),
        .rsp_mode              (rsp_mode),
        .rsp_data              (rsp_data),
        .rsp_err               (rsp_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_ch(input int ch, input logic mode, input logic [DW-1:0] d,
                          input logic [DW-1:0] k);
        req_mode[ch]            = mode;
        req_data[ch*DW +: DW]   = d;
        req_key[ch*DW +: DW]    = k;
    endtask

    // Steps until rsp_valid is seen; cycles = steps taken, or -1 if the budget expires.
    task automatic wait_rsp(input int max_cycles, output int cycles);
        cycles = -1;
        for (int i = 1; i <= max_cycles; i++) begin
            step();
            if (rsp_valid) begin
                cycles = i;
                break;
            end
        end
    endtask

    // Core model: done strobe core_lat cycles after the start pulse cycle.
    int            core_lat     = 10;
    bit            core_en      = 1'b1;
    bit            spurious_enc = 1'b0;
    logic [DW-1:0] enc_result   = '0;
    logic [DW-1:0] dec_result   = '0;
    int            enc_cnt      = 0;
    int            dec_cnt      = 0;
    int            spur_cnt     = 0;

    initial begin
        done_encryption       = 1'b0;
        done_decyption        = 1'b0;
        cyphertext_encryption = '0;
        plaintext_decryption  = '0;
        forever begin
            @(posedge clk);
            #1;
            done_encryption = 1'b0;
            done_decyption  = 1'b0;
            if (enc_cnt > 0) begin
                enc_cnt--;
                if (enc_cnt == 0) begin
                    done_encryption       = 1'b1;
                    cyphertext_encryption = enc_result;
                end
            end
            if (dec_cnt > 0) begin
                dec_cnt--;
                if (dec_cnt == 0) begin
                    done_decyption       = 1'b1;
                    plaintext_decryption = dec_result;
                end
            end
            if (spur_cnt > 0) begin
                spur_cnt--;
                if (spur_cnt == 0) begin
                    done_encryption       = 1'b1;
                    cyphertext_encryption = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
                end
            end
            if (core_en && start_encryption) enc_cnt = core_lat;
            if (core_en && start_decryption) begin
                dec_cnt = core_lat;
                if (spurious_enc) spur_cnt = 3;
            end
        end
    end

    localparam logic [DW-1:0] Pt1  = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [DW-1:0] Key1 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [DW-1:0] Ct1  = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;

    initial begin
        int cyc;
        int cnt;
        int vcount;
        int scount;
        logic [DW-1:0] d_ch [NCH];

        rst       = 1'b0;
        req_valid = '1;
        req_mode  = '0;
        req_data  = '0;
        req_key   = '0;
        rsp_ready = 1'b0;

        // Reset state, with requests pending that must not be offered.
        step(); step(); step();
        settle();
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_start_enc", start_encryption, 0);
        check_eq("rst_start_dec", start_decryption, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_rsp_ch", rsp_ch, 0);
        check_eq("rst_key", key_encryption, 0);
        rst       = 1'b1;
        req_valid = '0;
        settle();
        check_eq("post_rst_ready", req_ready, 0);

        // Single encrypt on ch0 with a 10-cycle core.
        step();
        rsp_ready  = 1'b1;
        enc_result = Ct1;
        set_ch(0, 1'b0, Pt1, Key1);
        req_valid  = 4'b0001;
        settle();
        check_eq("t1_grant", req_ready, 4'b0001);
        step();
        req_valid = '0;
        settle();
        check_eq("t1_start_enc", start_encryption, 1);
        check_eq("t1_start_dec", start_decryption, 0);
        check_eq("t1_pt_op", plaintext_encryption, Pt1);
        check_eq("t1_key_op", key_encryption, Key1);
        check_eq("t1_ready_busy", req_ready, 0);
        step();
        check_eq("t1_start_one_cycle", start_encryption, 0);
        wait_rsp(40, cyc);
        check_eq("t1_latency", cyc, 10);
        check_eq("t1_rsp_ch", rsp_ch, 0);
        check_eq("t1_rsp_mode", rsp_mode, 0);
        check_eq("t1_rsp_data", rsp_data, Ct1);
        check_eq("t1_rsp_err", rsp_err, 0);

        // Decrypt on ch2 with a spurious encrypt done during WAIT (rr_ptr now 1).
        step();
        spurious_enc = 1'b1;
        dec_result   = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
        set_ch(2, 1'b1, 128'ha5a5a5a5_11111111_22222222_33333333,
               128'h5a5a5a5a_44444444_55555555_66666666);
        req_valid = 4'b0100;
        settle();
        check_eq("t3_grant", req_ready, 4'b0100);
        step();
        req_valid = '0;
        settle();
        check_eq("t3_start_dec", start_decryption, 1);
        check_eq("t3_start_enc", start_encryption, 0);
        check_eq("t3_ct_op", cyphertext_decryption, 128'ha5a5a5a5_11111111_22222222_33333333);
        check_eq("t3_pt_hold", plaintext_encryption, Pt1);
        check_eq("t3_key_op", key_encryption, 128'h5a5a5a5a_44444444_55555555_66666666);
        wait_rsp(40, cyc);
        check_eq("t3_latency", cyc, 11);
        check_eq("t3_rsp_mode", rsp_mode, 1);
        check_eq("t3_rsp_ch", rsp_ch, 2);
        check_eq("t3_rsp_data", rsp_data, 128'h0f0e0d0c_0b0a0908_07060504_03020100);
        spurious_enc = 1'b0;

        // Response backpressure: ch3 granted (rr_ptr 3), ch1 kept pending.
        step();
        rsp_ready  = 1'b0;
        core_lat   = 3;
        enc_result = 128'h13579bdf_2468ace0_13579bdf_2468ace0;
        set_ch(3, 1'b0, 128'h33, 128'h3333);
        set_ch(1, 1'b0, 128'h11, 128'h1111);
        req_valid = 4'b1010;
        settle();
        check_eq("t4_grant", req_ready, 4'b1000);
        step();
        req_valid = 4'b0010;
        wait_rsp(20, cyc);
        check_eq("t4_latency", cyc, 4);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq($sformatf("t4_hold_valid_%0d", i), rsp_valid, 1);
            check_eq($sformatf("t4_hold_ch_%0d", i), rsp_ch, 3);
            check_eq($sformatf("t4_hold_data_%0d", i), rsp_data,
                     128'h13579bdf_2468ace0_13579bdf_2468ace0);
            check_eq($sformatf("t4_hold_ready_%0d", i), req_ready, 0);
        end
        rsp_ready = 1'b1;
        step();
        settle();
        check_eq("t4_next_grant", req_ready, 4'b0010);
        check_eq("t4_rsp_dropped", rsp_valid, 0);
        step();
        req_valid = '0;
        wait_rsp(20, cyc);
        check_eq("t4_ch1_rsp_ch", rsp_ch, 1);
        step();

        // Round-robin with all channels requesting, from a fresh rr_ptr of 0.
        rst = 1'b0;
        step(); step();
        rst      = 1'b1;
        core_lat = 2;
        for (int c = 0; c < NCH; c++) begin
            d_ch[c] = DW'(32'hc0de0000 + c);
            set_ch(c, 1'b0, d_ch[c], DW'(c));
        end
        req_valid = '1;
        for (int g = 0; g < 5; g++) begin
            cnt = 0;
            settle();
            while (req_ready == 0 && cnt < 20) begin
                step();
                cnt++;
            end
            check_eq($sformatf("rr_grant_%0d", g), req_ready, DW'(1 << (g % NCH)));
            step();
            check_eq($sformatf("rr_operand_%0d", g), plaintext_encryption, d_ch[g % NCH]);
            wait_rsp(20, cyc);
            check_eq($sformatf("rr_rsp_ch_%0d", g), rsp_ch, g % NCH);
            step();
        end
        req_valid = '0;

        // Reset in WAIT, then a late core done must produce nothing.
        core_lat = 10;
        set_ch(0, 1'b0, Pt1, Key1);
        step();
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        step(); step(); step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        check_eq("t6_ready", req_ready, 0);
        check_eq("t6_start_enc", start_encryption, 0);
        check_eq("t6_rsp_valid", rsp_valid, 0);
        check_eq("t6_rsp_ch", rsp_ch, 0);
        check_eq("t6_rsp_mode", rsp_mode, 0);
        check_eq("t6_rsp_data", rsp_data, 0);
        check_eq("t6_rsp_err", rsp_err, 0);
        check_eq("t6_pt_op", plaintext_encryption, 0);
        check_eq("t6_key_op", key_encryption, 0);
        vcount = 0;
        scount = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rsp_valid) vcount++;
            if (start_encryption || start_decryption) scount++;
        end
        check_eq("t6_no_rsp_after_late_done", vcount, 0);
        check_eq("t6_no_start", scount, 0);

        // Core never answers.
        core_en = 1'b0;
        set_ch(1, 1'b0, 128'h77, 128'h7777);
        req_valid = 4'b0010;
        settle();
        check_eq("t7_grant", req_ready, 4'b0010);
        step();
        req_valid = '0;
        wait_rsp(30, cyc);
`ifdef AES_SCHED_TIMEOUT_EN
        check_eq("t7_timeout_latency", cyc, 9);
        check_eq("t7_rsp_err", rsp_err, 1);
        check_eq("t7_rsp_data", rsp_data, 0);
        check_eq("t7_rsp_ch", rsp_ch, 1);
        step();
`else
        check_eq("t7_no_rsp", cyc, -1);
        req_valid = 4'b0001;
        settle();
        check_eq("t7_stuck_ready", req_ready, 0);
        check_eq("t7_rsp_err", rsp_err, 0);
        req_valid = '0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_req_scheduler.md
AES_REQ_SCHEDULER -- requirements
Module: aes_req_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of requester channels (1..16).
REQ-002 SHALL have parameter DATA_WIDTH, default aes_package DATA_WIDTH (128), block width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, watchdog limit (used only under REQ-030).
REQ-004 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_valid  in  NUM_CH  per-channel request valid.
REQ-007 SHALL have port req_ready  out  NUM_CH  per-channel request accept.
REQ-008 SHALL have port req_mode  in  NUM_CH  per-channel mode, 0 encrypt, 1 decrypt.
REQ-009 SHALL have port req_data  in  NUM_CH*DATA_WIDTH  per-channel plaintext/cyphertext, channel i at slice i.
REQ-010 SHALL have port req_key  in  NUM_CH*DATA_WIDTH  per-channel key, channel i at slice i.
REQ-011 SHALL have ports start_encryption, start_decryption  out  1 each  one-cycle core start pulses.
REQ-012 SHALL have ports plaintext_encryption, cyphertext_decryption, key_encryption  out  DATA_WIDTH each  core operands.
REQ-013 SHALL have ports cyphertext_encryption, plaintext_decryption  in  DATA_WIDTH each  core results.
REQ-014 SHALL have ports done_encryption, done_decyption  in  1 each  core completion strobes.
REQ-015 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_ch out $clog2(NUM_CH) (min 1), rsp_mode out 1, rsp_data out DATA_WIDTH, rsp_err out 1.

Function
REQ-016 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, one request in flight.
REQ-017 IDLE: SHALL grant the lowest-index asserted req_valid at or after rr_ptr, wrapping NUM_CH-1 -> 0; req_ready[grant] SHALL be high in the same cycle, all other req_ready bits low; handshake = req_valid & req_ready.
REQ-018 On handshake SHALL register channel, mode, data, key; set rr_ptr = grant+1 modulo NUM_CH; go to ISSUE.
REQ-019 ISSUE: SHALL pulse exactly one of start_encryption/start_decryption (per registered mode) for one cycle, with operands driven stable from ISSUE through WAIT; go to WAIT.
REQ-020 WAIT: SHALL accept only the done strobe matching the registered mode; the other strobe SHALL be ignored; on match, capture the matching result into rsp_data and go to RESP.
REQ-021 RESP: rsp_valid high; rsp_ch, rsp_mode, rsp_data, rsp_err stable until rsp_valid & rsp_ready; then IDLE.
REQ-022 No request SHALL be accepted outside IDLE; req_ready SHALL be all-zero in ISSUE, WAIT and RESP.
REQ-023 Minimum latency, handshake cycle to rsp_valid: 2 cycles plus core latency; IDLE re-arbitrates the cycle after the rsp handshake.
REQ-024 Operand outputs not driven by an active request SHALL hold their last value; start pulses SHALL be 0 outside ISSUE.
REQ-025 NUM_CH=1 SHALL degenerate to a pass-through with rsp_ch constant 0.

Reset
REQ-026 While rst=0 at a clock edge: state=IDLE, rr_ptr=0, req_ready=0, start_*=0, rsp_valid=0, rsp_err=0, rsp_ch=0, rsp_mode=0, rsp_data=0, operand registers=0.
REQ-027 Reset mid-operation SHALL abandon the in-flight request with no response; a late core done after reset SHALL be ignored in IDLE.
REQ-028 req_ready SHALL be 0 in the first cycle after reset deassertion if no req_valid; grant is evaluated combinationally thereafter.

Configuration
REQ-029 Macro AES_SCHED_TIMEOUT_EN SHALL control the watchdog.
REQ-030 Defined: WAIT counter starts at 0 on entry; if it reaches TIMEOUT_CYCLES without matching done, go to RESP with rsp_err=1, rsp_data=0; a done arriving in the limit cycle wins (rsp_err=0).
REQ-031 Undefined: no counter; WAIT lasts until matching done; rsp_err tied 0.

Structure
REQ-032 aes_package SHALL hold DATA_WIDTH, mode enum (MODE_ENC=0, MODE_DEC=1) and FSM state enum.
REQ-033 Round-robin grant logic SHALL be a sub-module aes_rr_arbiter (parameter NUM_CH; inputs req, ptr; output one-hot grant).

Verification
REQ-034 Single encrypt ch0, key 000102..0f, plaintext 00112233..eeff, core model done after 10 cycles -> rsp_ch=0, rsp_mode=0, rsp_data=69c4e0d8..c55a, rsp_valid at handshake+12.
REQ-035 All 4 channels valid continuously, rr_ptr=0 -> grants in order 0,1,2,3,0; no channel granted twice before others served.
REQ-036 Decrypt on ch2 with spurious done_encryption during WAIT -> strobe ignored; response only on done_decyption, rsp_mode=1.
REQ-037 rsp_ready held 0 for 5 cycles in RESP -> rsp fields stable, req_ready all-zero, next grant one cycle after rsp_ready=1.
REQ-038 rst=0 asserted in WAIT, then a late done -> no rsp_valid, all outputs at REQ-026 values.
REQ-039 With AES_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=8, core never responds -> rsp_err=1, rsp_data=0 after 8 WAIT cycles; without macro, FSM stays in WAIT.
